// File: rtl/fabric_pkg.sv
// rtl/fabric_pkg.sv - shared fabric error codes, error type and class helper
package fabric_pkg;

  typedef logic [15:0] fabric_err_t;

  localparam fabric_err_t FABRIC_OK       = 16'h0000;
  localparam fabric_err_t CFG_BAD_ADDR    = 16'h0001;
  localparam fabric_err_t CFG_BAD_LEN     = 16'h0002;
  localparam fabric_err_t CFG_UNSUPPORTED = 16'h0003;
  localparam fabric_err_t CFG_TIMEOUT     = 16'h0004;
  localparam fabric_err_t RT_ROUTE_FAIL   = 16'h0100;
  localparam fabric_err_t RT_CRC          = 16'h0101;
  localparam fabric_err_t RT_OVERFLOW     = 16'h0102;
  localparam fabric_err_t RT_TIMEOUT      = 16'h0103;

  // Runtime-class codes occupy 0x0100 and above; everything below is configuration class.
  function automatic logic fabric_err_is_rt(input fabric_err_t code);
    return code[15:8] != 8'h00;
  endfunction

endpackage

// File: rtl/fabric_error_collector_if.sv
// rtl/fabric_error_collector_if.sv - valid/ready report stream carrying {src_idx, code}
interface fabric_error_collector_if #(
  parameter int DATA_W = 18
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [DATA_W-1:0] rpt_data;

  modport master (output rpt_valid, output rpt_data, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, output rpt_ready);
endinterface

// File: rtl/fabric_prio_enc.sv
// rtl/fabric_prio_enc.sv - lowest-index priority encoder with multiple-hit flag
module fabric_prio_enc #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic          multi_o
);

  // Scanning downwards leaves the lowest set index as the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o   = |req_i;
  assign multi_o = |(req_i & (req_i - 1'b1));

endmodule

// File: rtl/fabric_error_collector.sv
// rtl/fabric_error_collector.sv - sticky first-error capture, one-shot report and drop counter
module fabric_error_collector
  import fabric_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int CNT_WIDTH = 8,
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC*16-1:0]  src_code,
  fabric_error_collector_if.master rpt,
  output logic                   err_flag,
  output logic                   err_is_rt,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  input  logic                   clear
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  fabric_err_t          code_q, code_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NUM_SRC-1:0]   active;
  logic                 any_act, multi_act;
  logic [IDX_W-1:0]     win_idx;
  fabric_err_t          win_code;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      active[i] = src_valid[i] && (src_code[i*16 +: 16] != FABRIC_OK);
    end
  end

  fabric_prio_enc #(.N(NUM_SRC)) u_prio (
    .req_i   (active),
    .any_o   (any_act),
    .idx_o   (win_idx),
    .multi_o (multi_act)
  );

  assign win_code = src_code[win_idx*16 +: 16];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_act) begin
          state_d = ST_PENDING;
          idx_d   = win_idx;
          code_d  = win_code;
          cnt_d   = CNT_WIDTH'(multi_act);
        end
      end
      ST_PENDING: begin
        // clear is deliberately ignored so an offered record is never withdrawn.
        if (any_act)       cnt_d   = cnt_inc;
        if (rpt.rpt_ready) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (clear) begin
          cnt_d = CNT_WIDTH'(multi_act);
          if (any_act) begin
            state_d = ST_PENDING;
            idx_d   = win_idx;
            code_d  = win_code;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (any_act) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      code_q  <= FABRIC_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rpt.rpt_valid = (state_q == ST_PENDING);
  assign rpt.rpt_data  = (state_q == ST_IDLE) ? '0 : {idx_q, code_q};
  assign err_flag      = (state_q != ST_IDLE);
  assign err_is_rt     = (state_q != ST_IDLE) && fabric_err_is_rt(code_q);
  assign drop_cnt      = cnt_q;

endmodule
